// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch and decode stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   XLEN          datapath/address width seen by every stage
//   NOP_INSTR     canonical RV32I NOP (addi x0, x0, 0)
//   fetch_entry_t {pc, instr} pair handed from IF to ID
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic circular buffer with synchronous flush and simultaneous push/pop.
// Latency: a pushed entry becomes visible at the head the cycle after the push edge.
// Backpressure: none internally; the producer must not push when full without a pop.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush_i             empty the buffer at the edge (wins over push and pop)
//   push_i, push_dat_i  write one entry
//   pop_i               remove the head entry (ignored when empty)
//   head_vld_o          buffer holds at least one entry
//   head_dat_o          oldest entry (contents undefined when empty)
//   count_o             number of stored entries
module fetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [63:0],
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output entry_t           head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        // A push into a full buffer is only safe when the head leaves in the same cycle.
        push_ok  = push_i && ((count_q != FULL_CNT) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// IF stage: owns the PC, fetches from a 1-cycle synchronous imem, buffers {pc,instr} for ID.
// Latency: request in cycle N -> instruction at the ID interface in cycle N+2; 1 instr/cycle steady.
// Backpressure: id_ready low holds the head; issue stops once buffered + in-flight reaches FBUF_DEPTH.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   imem_req, imem_addr           fetch request and word-aligned address (= pc_q)
//   imem_rdata                    instruction, valid the cycle after an accepted request
//   if_valid, if_instr, if_pc     head of the fetch buffer (NOP / 0 when empty)
//   id_ready                      ID consumes the head this cycle
//   redirect_valid, redirect_pc   taken branch/jump from EX: flush and restart at target
module ifetch_stage
    import pipe_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(FBUF_DEPTH + 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;

    logic [CNT_W-1:0] buf_count;
    logic             head_vld;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occ_after_pop;
    logic             redirect_lsb_unused;

    // Instructions are word aligned; the low target bits carry no information.
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    always_comb begin
        pop = head_vld && id_ready;
        // Reserve a slot for every outstanding fetch so a response always has room,
        // while crediting back the slot ID frees this cycle to keep full throughput.
        occ_after_pop = {1'b0, buf_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue = !reset && !redirect_valid &&
                (occ_after_pop < (CNT_W+1)'(FBUF_DEPTH));
        // A response belonging to a fetch issued before a redirect is dropped.
        push = inflight_q && !kill_q;
        push_entry.pc    = inflight_pc_q;
        push_entry.instr = imem_rdata;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        kill_d        = redirect_valid;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (issue) begin
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
        end
    end

    // Redirect flushes at the edge; a pop in the same cycle is still a valid hand-off
    // because the head is older than the redirecting branch.
    fetch_fifo #(
        .DEPTH   (FBUF_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fbuf (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_vld_o (head_vld),
        .head_dat_o (head_entry),
        .count_o    (buf_count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign if_valid  = head_vld;
    assign if_instr  = head_vld ? head_entry.instr : NOP_INSTR;
    assign if_pc     = head_vld ? head_entry.pc    : '0;

endmodule
